matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  UART-fed matrix multiplier. Receives dimensions M, N, P, then matrix A (MxN) and matrix B (NxP)
//  as 32-bit big-endian words over an 8N1 serial line, and computes C = A*B.
//  It then asserts done, exposes C on a parallel port and streams C back over the UART TX line.
//  Sits between the host serial link and downstream logic that consumes the result array.
// PARAMETERS
//  MAX_M       4         max rows of A / C
//  MAX_N       4         max cols of A = rows of B
//  MAX_P       4         max cols of B / C
//  CLOCK_FREQ  50000000  clk frequency, Hz
//  BAUD_RATE   9600      serial bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (5208 at defaults)
// PORTS
//  clk      in   1   system clock; one clock domain
//  rst_n    in   1   asynchronous, active-low reset
//  uart_rx  in   1   serial input, idle high, 8N1, LSB first
//  uart_tx  out  1   serial output, idle high, 8N1, LSB first
//  done     out  1   high once C is valid
//  result   out  32 x [0:MAX_M-1][0:MAX_P-1]   unpacked array; C[i][j]; entries outside MxP read 0
// BEHAVIOUR
//  Reset values:
//   - uart_tx=1, done=0, all result entries 0.
//   - All storage cleared; FSM returns to RX_DIM.
//   - Reset mid-operation aborts everything, including a partial byte or word.
//  RX:
//   - uart_rx passes through a 2-flop synchronizer.
//   - A low level starts a byte; it is re-checked at half-bit and the byte is aborted if high.
//   - Data bits are sampled at mid-bit, every CLKS_PER_BIT cycles.
//   - Stop bit sampled at mid-bit must be 1, else the byte is discarded (framing error, no word progress).
//  Words:
//   - 4 consecutive bytes form one word, MSB byte first: word = {word[23:0], byte}.
//  Frame order:
//   - M, N, P, then A row-major (M*N words), then B row-major (N*P words).
//  Dimension handling:
//   - Each dimension is saturated to the range 1..MAX_x: 0 becomes 1, values above MAX become MAX.
//   - Element counts use the saturated values.
//  FSM states:
//   - RX_DIM -> RX_A after the 3rd word.
//   - RX_A -> RX_B after M*N words.
//   - RX_B -> COMPUTE after N*P words.
//   - COMPUTE -> TX_WAIT after the last MAC.
//   - TX_WAIT -> TX after one bit period.
//   - TX -> RX_DIM after the last byte's stop bit.
//  COMPUTE:
//   - One MAC per clk: acc += A[i][k]*B[k][j].
//   - Arithmetic is unsigned 32-bit, product and sum truncated mod 2^32.
//   - Latency is M*N*P plus at most 4 cycles.
//  done and result timing:
//   - result is updated and done rises in the same cycle COMPUTE ends.
//   - done stays high through TX and afterwards.
//   - done falls when the first start bit of a new frame is detected, or on reset.
//   - result holds its value until the next COMPUTE completes.
//  TX:
//   - The first start bit begins no earlier than CLKS_PER_BIT cycles after done rises.
//   - C is sent row-major, each word MSB byte first: 4*M*P bytes total.
//   - Each byte is start(0) + 8 data bits LSB first + stop(1), each bit held CLKS_PER_BIT cycles.
//   - Bytes are back-to-back with no extra idle.
//  Concurrency:
//   - uart_rx activity during COMPUTE, TX_WAIT and TX is ignored.
//   - RX is re-armed in RX_DIM after TX finishes.
//  Storage:
//   - A is [MAX_M][MAX_N] x 32 and B is [MAX_N][MAX_P] x 32.
//   - Unused entries are zeroed at each frame start.
// TESTING
//  1. 2x2x2 case:
//     - M=N=P=2, A={1,2,3,4}, B={5,6,7,8}.
//     - Required: done=1 and result = {19,22,43,50}.
//     - TX bytes: 00 00 00 13 00 00 00 16 00 00 00 2B 00 00 00 32.
//  2. 1x3x1 case:
//     - A={1,2,3}, B={4,5,6}.
//     - Required: C[0][0]=32 (0x00000020); all other result entries 0; 4 TX bytes.
//  3. 4x4x4 identity:
//     - A=I, B=rows {1..16}.
//     - Required: result equals B; 64 TX bytes in row-major order.
//  4. Overflow:
//     - M=N=P=1, A=0x00010000, B=0x00010001.
//     - Required: C = 0x00010000 (wraps mod 2^32).
//  5. Framing error:
//     - Corrupt the stop bit of one A byte, then resend the correct byte.
//     - Required: the result is identical to case 1.
//  6. Reset mid-frame:
//     - Drop rst_n after A is sent, release it, then send the full case-1 frame.
//     - Required: the correct case-1 result; done=0 and uart_tx=1 while reset is held.

Source files
------------

// File: rtl/matrix_loader.sv
// UART-fed matrix multiplier: receives M, N, P, A and B as big-endian 32-bit words,
// computes C = A*B with one MAC per clock, exposes C and streams it back over TX.
module matrix_loader #(
  parameter int MAX_M      = 4,
  parameter int MAX_N      = 4,
  parameter int MAX_P      = 4,
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        done,
  output logic [31:0] result [0:MAX_M-1][0:MAX_P-1]
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int MW  = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int NW  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PW  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {RX_DIM, RX_A, RX_B, COMPUTE, TX_WAIT, TX} state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

  state_t          state;
  rx_state_t       rx_st;
  logic            rx_s1, rx_s2, rx_en;
  logic [CW-1:0]   rx_cnt, tx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            byte_vld, start_ok;
  logic [1:0]      dim_idx, byte_cnt, tx_b;
  logic [23:0]     word_sh;
  logic [MW-1:0]   m_last, ci, nxt_i;
  logic [NW-1:0]   n_last, ck;
  logic [PW-1:0]   p_last, cj, nxt_j;
  logic [31:0]     acc, word, prod, sum, nxt_word;
  logic            word_vld;
  logic [3:0]      tx_bit;
  logic [9:0]      tx_sh;
  logic [31:0]     tx_wsh;
  logic [31:0]     a_mem [0:MAX_M-1][0:MAX_N-1];
  logic [31:0]     b_mem [0:MAX_N-1][0:MAX_P-1];
  logic [31:0]     c_mem [0:MAX_M-1][0:MAX_P-1];

  assign rx_en = (state == RX_DIM) || (state == RX_A) || (state == RX_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX byte engine; after a framing error it waits for the line to return high
  // so the tail of a broken frame cannot look like a fresh start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      byte_vld <= 1'b0;
      start_ok <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      start_ok <= 1'b0;
      if (!rx_en) begin
        rx_st  <= R_IDLE;
        rx_cnt <= '0;
      end else begin
        case (rx_st)
          R_IDLE: if (!rx_s2) begin
            rx_st  <= R_START;
            rx_cnt <= '0;
          end
          R_START: if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (rx_s2) rx_st <= R_IDLE;
            else begin
              rx_st    <= R_DATA;
              start_ok <= 1'b1;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
          R_DATA: if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
          R_STOP: if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              byte_vld <= 1'b1;
              rx_st    <= R_IDLE;
            end else rx_st <= R_BREAK;
          end else rx_cnt <= rx_cnt + 1'b1;
          default: if (rx_s2) rx_st <= R_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    word     = {word_sh, rx_sh};
    word_vld = byte_vld && (byte_cnt == 2'd3);
    prod     = a_mem[ci][ck] * b_mem[ck][cj];
    sum      = acc + prod;
    nxt_i    = ci;
    nxt_j    = cj + 1'b1;
    if (cj == p_last) begin
      nxt_i = ci + 1'b1;
      nxt_j = '0;
    end
    nxt_word = result[nxt_i][nxt_j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_DIM;
      uart_tx  <= 1'b1;
      done     <= 1'b0;
      dim_idx  <= '0;
      byte_cnt <= '0;
      word_sh  <= '0;
      m_last   <= '0;
      n_last   <= '0;
      p_last   <= '0;
      ci       <= '0;
      ck       <= '0;
      cj       <= '0;
      acc      <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_b     <= '0;
      tx_sh    <= '1;
      tx_wsh   <= '0;
      for (int i = 0; i < MAX_M; i++)
        for (int j = 0; j < MAX_N; j++) a_mem[i][j] <= '0;
      for (int i = 0; i < MAX_N; i++)
        for (int j = 0; j < MAX_P; j++) b_mem[i][j] <= '0;
      for (int i = 0; i < MAX_M; i++)
        for (int j = 0; j < MAX_P; j++) begin
          c_mem[i][j]  <= '0;
          result[i][j] <= '0;
        end
    end else begin
      if (start_ok) done <= 1'b0;
      if (byte_vld) begin
        word_sh  <= word[23:0];
        byte_cnt <= byte_cnt + 1'b1;
      end
      case (state)
        RX_DIM: if (word_vld) begin
          dim_idx <= dim_idx + 1'b1;
          case (dim_idx)
            2'd0: begin
              m_last <= (word == 32'd0) ? '0 : (word > 32'(MAX_M)) ? MW'(MAX_M - 1) : MW'(word - 32'd1);
              for (int i = 0; i < MAX_M; i++)
                for (int j = 0; j < MAX_N; j++) a_mem[i][j] <= '0;
              for (int i = 0; i < MAX_N; i++)
                for (int j = 0; j < MAX_P; j++) b_mem[i][j] <= '0;
              for (int i = 0; i < MAX_M; i++)
                for (int j = 0; j < MAX_P; j++) c_mem[i][j] <= '0;
            end
            2'd1: n_last <= (word == 32'd0) ? '0 : (word > 32'(MAX_N)) ? NW'(MAX_N - 1) : NW'(word - 32'd1);
            default: begin
              p_last  <= (word == 32'd0) ? '0 : (word > 32'(MAX_P)) ? PW'(MAX_P - 1) : PW'(word - 32'd1);
              dim_idx <= '0;
              state   <= RX_A;
            end
          endcase
        end
        RX_A: if (word_vld) begin
          a_mem[ci][ck] <= word;
          if (ck == n_last) begin
            ck <= '0;
            if (ci == m_last) begin
              ci    <= '0;
              state <= RX_B;
            end else ci <= ci + 1'b1;
          end else ck <= ck + 1'b1;
        end
        RX_B: if (word_vld) begin
          b_mem[ck][cj] <= word;
          if (cj == p_last) begin
            cj <= '0;
            if (ck == n_last) begin
              ck    <= '0;
              acc   <= '0;
              state <= COMPUTE;
            end else ck <= ck + 1'b1;
          end else cj <= cj + 1'b1;
        end
        COMPUTE: begin
          if (ck == n_last) begin
            ck          <= '0;
            acc         <= '0;
            c_mem[ci][cj] <= sum;
            if (cj == p_last) begin
              cj <= '0;
              if (ci == m_last) begin
                // Publish the whole array at once; the final element comes straight from the adder.
                for (int i = 0; i < MAX_M; i++)
                  for (int j = 0; j < MAX_P; j++) result[i][j] <= c_mem[i][j];
                result[ci][cj] <= sum;
                ci     <= '0;
                done   <= 1'b1;
                tx_cnt <= '0;
                state  <= TX_WAIT;
              end else ci <= ci + 1'b1;
            end else cj <= cj + 1'b1;
          end else begin
            ck  <= ck + 1'b1;
            acc <= sum;
          end
        end
        TX_WAIT: if (tx_cnt == BIT_END) begin
          tx_cnt  <= '0;
          tx_bit  <= '0;
          tx_b    <= '0;
          tx_sh   <= {1'b1, result[0][0][31:24], 1'b0};
          tx_wsh  <= {result[0][0][23:0], 8'h00};
          uart_tx <= 1'b0;
          state   <= TX;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX: if (tx_cnt != BIT_END) tx_cnt <= tx_cnt + 1'b1;
        else begin
          tx_cnt <= '0;
          if (tx_bit != 4'd9) begin
            tx_bit  <= tx_bit + 1'b1;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            uart_tx <= tx_sh[1];
          end else begin
            tx_bit <= '0;
            if (tx_b != 2'd3) begin
              tx_b    <= tx_b + 1'b1;
              tx_sh   <= {1'b1, tx_wsh[31:24], 1'b0};
              tx_wsh  <= {tx_wsh[23:0], 8'h00};
              uart_tx <= 1'b0;
            end else if (ci == m_last && cj == p_last) begin
              ci      <= '0;
              cj      <= '0;
              tx_b    <= '0;
              uart_tx <= 1'b1;
              state   <= RX_DIM;
            end else begin
              ci      <= nxt_i;
              cj      <= nxt_j;
              tx_b    <= '0;
              tx_sh   <= {1'b1, nxt_word[31:24], 1'b0};
              tx_wsh  <= {nxt_word[23:0], 8'h00};
              uart_tx <= 1'b0;
            end
          end
        end
        default: state <= RX_DIM;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: stimulus pushes expected C and TX bytes,
// independent monitors check the parallel result on done and decode the TX line.
`timescale 1ns/1ps
module tb_matrix_loader;
  localparam int MM = 4, MN = 4, MP = 4;
  localparam int CF = 600, BR = 100, CPB = CF / BR;

  logic        clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic        uart_tx, done;
  logic [31:0] result [0:MM-1][0:MP-1];

  matrix_loader #(.MAX_M(MM), .MAX_N(MN), .MAX_P(MP), .CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, errors = 0, frames_seen = 0;
  logic [31:0] exp_res[$];
  logic [7:0]  exp_tx[$];
  int unsigned rise_cyc = 0, last_st = 0;
  bit          first_byte = 1'b0;
  logic [31:0] qa[$], qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v == 0) ? 1 : (v > mx) ? mx : v;
  endfunction

  // Result monitor: a rising done consumes one expected C array.
  initial begin
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_q) begin
        rise_cyc   = cyc;
        first_byte = 1'b1;
        frames_seen++;
        if (exp_res.size() < MM * MP) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else
          for (int i = 0; i < MM; i++)
            for (int j = 0; j < MP; j++)
              check($sformatf("result[%0d][%0d]", i, j), result[i][j], exp_res.pop_front());
      end
      done_q = done;
    end
  end

  // TX monitor: UART decoder sampling at mid-bit.
  initial begin
    logic [7:0]  b;
    int unsigned st;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        st = cyc;
        if (first_byte) begin
          check("tx_first_start_delay_ok", 32'(st - rise_cyc >= CPB), 32'd1);
          first_byte = 1'b0;
        end else
          check("tx_byte_gap", st - last_st, 10 * CPB);
        last_st = st;
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_byte: got %h, expected none", b);
        end else
          check("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
      end
    end
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(!bad_stop);
    if (bad_stop) repeat (2) send_bit(1'b1);
  endtask

  task automatic send_words(input logic [31:0] w[$], input int bad_byte);
    int bn;
    bn = 0;
    foreach (w[x])
      for (int k = 3; k >= 0; k--) begin
        if (bn == bad_byte) send_byte(w[x][8*k +: 8], 1'b1);
        send_byte(w[x][8*k +: 8], 1'b0);
        if (bn == 0) check("done_low_after_start", {31'b0, done}, 32'd0);
        bn++;
      end
  endtask

  task automatic run_frame(input int m, input int n, input int p,
                           input logic [31:0] a[$], input logic [31:0] b[$], input int bad_byte);
    int ms, ns, ps, target, t;
    logic [31:0] c;
    logic [31:0] w[$];
    ms = sat(m, MM); ns = sat(n, MN); ps = sat(p, MP);
    for (int i = 0; i < MM; i++)
      for (int j = 0; j < MP; j++) begin
        c = 32'd0;
        if (i < ms && j < ps) begin
          for (int k = 0; k < ns; k++) c = c + a[i*ns+k] * b[k*ps+j];
          for (int y = 3; y >= 0; y--) exp_tx.push_back(c[8*y +: 8]);
        end
        exp_res.push_back(c);
      end
    w.push_back(32'(m)); w.push_back(32'(n)); w.push_back(32'(p));
    for (int i = 0; i < ms * ns; i++) w.push_back(a[i]);
    for (int i = 0; i < ns * ps; i++) w.push_back(b[i]);
    target = frames_seen + 1;
    send_words(w, bad_byte);
    t = 0;
    while (frames_seen < target && t < ms * ns * ps + 6) begin
      @(negedge clk);
      t++;
    end
    check("done_within_latency", 32'(frames_seen >= target), 32'd1);
    t = 0;
    while (exp_tx.size() != 0 && t < (4 * ms * ps + 2) * 10 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("tx_all_bytes_sent", exp_tx.size(), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    check("done_holds_after_tx", {31'b0, done}, 32'd1);
  endtask

  task automatic load_case1();
    qa.delete(); qb.delete();
    for (int i = 1; i <= 4; i++) begin
      qa.push_back(32'(i));
      qb.push_back(32'(i + 4));
    end
  endtask

  initial begin
    logic [31:0] w[$];
    int m, n, p;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result00", result[0][0], 32'd0);
    check("reset_result33", result[3][3], 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    load_case1();
    run_frame(2, 2, 2, qa, qb, -1);
    check("case1_c00", result[0][0], 32'd19);
    check("case1_c01", result[0][1], 32'd22);
    check("case1_c10", result[1][0], 32'd43);
    check("case1_c11", result[1][1], 32'd50);

    qa.delete(); qb.delete();
    for (int i = 1; i <= 3; i++) begin
      qa.push_back(32'(i));
      qb.push_back(32'(i + 3));
    end
    run_frame(1, 3, 1, qa, qb, -1);
    check("case2_c00", result[0][0], 32'h20);
    check("case2_c11_cleared", result[1][1], 32'd0);

    qa.delete(); qb.delete();
    for (int i = 0; i < 16; i++) begin
      qa.push_back((i / 4 == i % 4) ? 32'd1 : 32'd0);
      qb.push_back(32'(i + 1));
    end
    run_frame(4, 4, 4, qa, qb, -1);
    check("case3_c33", result[3][3], 32'd16);

    qa.delete(); qb.delete();
    qa.push_back(32'h00010000); qb.push_back(32'h00010001);
    run_frame(1, 1, 1, qa, qb, -1);
    check("case4_wrap", result[0][0], 32'h00010000);

    load_case1();
    run_frame(2, 2, 2, qa, qb, 12 + 5);
    check("case5_c11", result[1][1], 32'd50);

    // Partial frame (dims + A) aborted by reset.
    w.delete();
    w.push_back(32'd2); w.push_back(32'd2); w.push_back(32'd2);
    for (int i = 1; i <= 4; i++) w.push_back(32'(i));
    send_words(w, -1);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_hold_done", {31'b0, done}, 32'd0);
    check("rst_hold_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_hold_result", result[1][1], 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    load_case1();
    run_frame(2, 2, 2, qa, qb, -1);
    check("case6_c10", result[1][0], 32'd43);

    // Randomized frames; raw dims 0..5 exercise saturation.
    for (int r = 0; r < 3; r++) begin
      m = $urandom_range(0, 5); n = $urandom_range(0, 5); p = $urandom_range(0, 5);
      qa.delete(); qb.delete();
      for (int i = 0; i < sat(m, MM) * sat(n, MN); i++) qa.push_back($urandom);
      for (int i = 0; i < sat(n, MN) * sat(p, MP); i++) qb.push_back((r == 0) ? 32'($urandom_range(0, 255)) : $urandom);
      run_frame(m, n, p, qa, qb, -1);
    end

    check("scoreboard_res_empty", exp_res.size(), 32'd0);
    check("scoreboard_tx_empty", exp_tx.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
